uart_rx_frame: RTL and testbench

Parametrised UART receiver for the peripheral bus: 5–9 data bits, optional even/odd parity, one or two stop bits, 3-sample majority voting, and parity/framing/break reporting. It sits between the board RX pin and the UART register block. It replaces the fixed 8N1 receiver wherever frame format or error reporting is needed.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_sampler.sv | 33 +++
 rtl/uart_rx_frame.sv | 172 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    CLEANUP   = 3'd5,
    WAIT_HIGH = 3'd6
  } state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Total bit periods on the line for one frame, start bit included.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX pin synchroniser plus a three-sample majority vote over the last three
// synchronised values (two registered, one current).
module uart_rx_sampler (
  input  logic clk,
  input  logic reset,
  input  logic rx_serial,
  output logic rx_s,
  output logic voted
);

  logic       sync1;
  logic       sync2;
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 2'b11;
    end else begin
      sync1 <= rx_serial;
      sync2 <= sync1;
      hist  <= {hist[0], sync2};
    end
  end

  assign rx_s = sync2;

  // When the bit counter sits at its last count, hist holds the two previous
  // counts and rx_s the current one, so the vote spans the final three counts.
  assign voted = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);

endmodule

// File: rtl/uart_rx_frame.sv
// Framed UART receiver: configurable data width, parity and stop bits, with
// parity, framing and break reporting qualified by the data-valid pulse.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam int              HALF      = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_HALF  = CW'(HALF);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 8 || CLKS_PER_BIT > 511) begin : g_bad_clks
    $error("uart_rx_frame: CLKS_PER_BIT must be 8..511");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_rx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_par
    $error("uart_rx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_frame: STOP_BITS must be 1 or 2");
  end

  state_e               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 stop_err;
  logic                 first_stop_low;

  logic rx_s;
  logic voted;
  logic bit_end;

  logic stop_err_n;
  logic first_low_n;
  logic par_err_n;
  logic brk_n;

  uart_rx_sampler u_sampler (
    .clk       (i_Clock),
    .reset     (i_Reset),
    .rx_serial (i_Rx_Serial),
    .rx_s      (rx_s),
    .voted     (voted)
  );

  assign bit_end = (cnt == CNT_LAST);
  assign o_Busy  = (state != IDLE);

  // Frame status as it would stand once the current stop bit is folded in.
  always_comb begin
    stop_err_n  = stop_err | ~voted;
    first_low_n = (bit_idx == 4'd0) ? ~voted : first_stop_low;
    par_err_n   = 1'b0;
    if (PARITY == PAR_EVEN)     par_err_n = ^{shreg, par_bit};
    else if (PARITY == PAR_ODD) par_err_n = ~(^{shreg, par_bit});
    brk_n = (shreg == '0) && ((PARITY == PAR_NONE) || !par_bit) && first_low_n;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      shreg          <= '0;
      par_bit        <= 1'b0;
      stop_err       <= 1'b0;
      first_stop_low <= 1'b0;
      o_Rx_DV        <= 1'b0;
      o_Rx_Byte      <= '0;
      o_Parity_Err   <= 1'b0;
      o_Frame_Err    <= 1'b0;
      o_Break        <= 1'b0;
    end else begin
      o_Rx_DV <= 1'b0;
      case (state)
        IDLE: begin
          cnt            <= '0;
          bit_idx        <= '0;
          stop_err       <= 1'b0;
          first_stop_low <= 1'b0;
          if (!rx_s) state <= START;
        end

        // Mid-start-bit recheck rejects short glitches on the line.
        START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt   <= '0;
            shreg <= {voted, shreg[DATA_BITS-1:1]};
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        uart_pkg::PARITY: begin
          if (bit_end) begin
            cnt     <= '0;
            par_bit <= voted;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt            <= '0;
            stop_err       <= stop_err_n;
            first_stop_low <= first_low_n;
            if (bit_idx == STOP_LAST) begin
              bit_idx      <= '0;
              o_Rx_DV      <= 1'b1;
              o_Rx_Byte    <= shreg;
              o_Parity_Err <= par_err_n;
              o_Frame_Err  <= stop_err_n;
              o_Break      <= brk_n;
              // A low final stop bit means the line may still be held low;
              // wait for it to recover before hunting for a new start bit.
              state        <= voted ? CLEANUP : WAIT_HIGH;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        CLEANUP: state <= IDLE;

        WAIT_HIGH: if (rx_s) state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench: three receivers (8N1, 7E1, 8N2 at 16 clocks/bit) driven
// with directed and random frames; expectations come from a frame-level model.
module tb_uart_rx_frame;

  localparam int C = 16;
  localparam int H = (C - 1) / 2;
  localparam int DB [3] = '{8, 7, 8};
  localparam int PB [3] = '{0, 1, 0};
  localparam int SB [3] = '{1, 1, 2};

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] rx_line = 3'b111;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  logic       dv0, dv1, dv2, pe0, pe1, pe2, fe0, fe1, fe2, bk0, bk1, bk2, by0, by1, by2;
  logic [7:0] b0;
  logic [6:0] b1;
  logic [7:0] b2;
  logic [2:0] dv, perr, ferr, brk, busy;
  logic [8:0] byt [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[0]), .o_Rx_DV(dv0), .o_Rx_Byte(b0),
    .o_Parity_Err(pe0), .o_Frame_Err(fe0), .o_Break(bk0), .o_Busy(by0));
  uart_rx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[1]), .o_Rx_DV(dv1), .o_Rx_Byte(b1),
    .o_Parity_Err(pe1), .o_Frame_Err(fe1), .o_Break(bk1), .o_Busy(by1));
  uart_rx_frame #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx_line[2]), .o_Rx_DV(dv2), .o_Rx_Byte(b2),
    .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Break(bk2), .o_Busy(by2));

  assign dv   = {dv2, dv1, dv0};
  assign perr = {pe2, pe1, pe0};
  assign ferr = {fe2, fe1, fe0};
  assign brk  = {bk2, bk1, bk0};
  assign busy = {by2, by1, by0};
  assign byt[0] = {1'b0, b0};
  assign byt[1] = {2'b0, b1};
  assign byt[2] = {1'b0, b2};

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  // Monitor: every DV pops the oldest expected frame for that receiver.
  logic [2:0] dv_prev = 3'b000;
  exp_t       m_e;
  logic       m_have;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (dv[i]) begin
          m_have = 1'b0;
          case (i)
            0: if (q0.size() != 0) begin m_e = q0.pop_front(); m_have = 1'b1; end
            1: if (q1.size() != 0) begin m_e = q1.pop_front(); m_have = 1'b1; end
            default: if (q2.size() != 0) begin m_e = q2.pop_front(); m_have = 1'b1; end
          endcase
          chk("dv_single_cycle", i, {31'd0, dv_prev[i]}, 32'd0);
          if (!m_have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_dv inst%0d: got DV with no frame outstanding (cycle %0d)", i, cyc);
          end else begin
            chk("dv_cycle", i, cyc, m_e.cyc);
            chk("data", i, {23'd0, byt[i]}, {23'd0, m_e.data});
            chk("parity_err", i, {31'd0, perr[i]}, {31'd0, m_e.perr});
            chk("frame_err", i, {31'd0, ferr[i]}, {31'd0, m_e.ferr});
            chk("break", i, {31'd0, brk[i]}, {31'd0, m_e.brk});
          end
        end
      end
    end
    dv_prev <= dv;
  end

  task automatic push(input int inst, input exp_t e);
    case (inst)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Drives one whole frame; call at #1 after a rising edge. gbit is the frame
  // bit index that gets a one-cycle inverted glitch at offset goff (-1: none).
  task automatic send(input int inst, input logic [8:0] data, input logic pbit,
                      input logic s0, input logic s1, input int gbit, input int goff);
    logic [15:0] bits;
    int          n;
    int          ones;
    exp_t        e;
    bits = '0;
    n = 1;
    for (int j = 0; j < DB[inst]; j++) begin bits[n] = data[j]; n++; end
    if (PB[inst] != 0) begin bits[n] = pbit; n++; end
    bits[n] = s0; n++;
    if (SB[inst] == 2) begin bits[n] = s1; n++; end

    e.data = 9'(int'(data) % (1 << DB[inst]));
    ones   = $countones(e.data) + int'(pbit);
    e.perr = (PB[inst] == 1) ? (ones % 2 == 1) : (PB[inst] == 2) ? (ones % 2 == 0) : 1'b0;
    e.ferr = !s0 || (SB[inst] == 2 && !s1);
    e.brk  = (e.data == 0) && (PB[inst] == 0 || !pbit) && !s0;
    e.cyc  = cyc + 4 + H + C * (n - 1);
    push(inst, e);

    for (int i = 0; i < n; i++) begin
      rx_line[inst] = bits[i];
      if (i == gbit) begin
        repeat (goff) @(posedge clk);
        #1 rx_line[inst] = ~bits[i];
        @(posedge clk);
        #1 rx_line[inst] = bits[i];
        repeat (C - goff - 1) @(posedge clk);
        #1;
      end else begin
        repeat (C) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic hold(input int inst, input logic v, input int ncyc);
    rx_line[inst] = v;
    repeat (ncyc) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] d;
    logic       pb, s0, s1;
    int         gb, go, gap;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_dv", i, {31'd0, dv[i]}, 32'd0);
      chk("reset_byte", i, {23'd0, byt[i]}, 32'd0);
      chk("reset_flags", i, {29'd0, perr[i], ferr[i], brk[i]}, 32'd0);
      chk("reset_busy", i, {31'd0, busy[i]}, 32'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // 8N1 clean frame; latency checked by the monitor.
    send(0, 9'h0A5, 1'b0, 1'b1, 1'b1, -1, 0);
    hold(0, 1'b1, C);

    // 7E1: 0x41 with correct and wrong parity bit.
    send(1, 9'h041, 1'b0, 1'b1, 1'b1, -1, 0);
    hold(1, 1'b1, C);
    send(1, 9'h041, 1'b1, 1'b1, 1'b1, -1, 0);
    hold(1, 1'b1, C);

    // 8N2 with low second stop bit, line held low afterwards; no second DV.
    send(2, 9'h096, 1'b0, 1'b1, 1'b0, -1, 0);
    hold(2, 1'b0, 3 * C);
    @(negedge clk);
    chk("busy_wait_high", 2, {31'd0, busy[2]}, 32'd1);
    @(posedge clk); #1;
    hold(2, 1'b1, C);
    send(2, 9'h03B, 1'b0, 1'b1, 1'b1, -1, 0);
    hold(2, 1'b1, C);

    // Line held low 20 bit times: one break frame, busy until line recovers.
    send(0, 9'h000, 1'b0, 1'b0, 1'b0, -1, 0);
    @(negedge clk);
    chk("busy_break_a", 0, {31'd0, busy[0]}, 32'd1);
    @(posedge clk); #1;
    hold(0, 1'b0, 10 * C - 1);
    @(negedge clk);
    chk("busy_break_b", 0, {31'd0, busy[0]}, 32'd1);
    @(posedge clk); #1;
    hold(0, 1'b1, 4);
    @(negedge clk);
    chk("busy_after_break", 0, {31'd0, busy[0]}, 32'd0);
    @(posedge clk); #1;
    hold(0, 1'b1, C);

    // Start glitch of five cycles is rejected.
    hold(0, 1'b0, 5);
    hold(0, 1'b1, 3 * C);
    @(negedge clk);
    chk("busy_after_glitch", 0, {31'd0, busy[0]}, 32'd0);
    @(posedge clk); #1;

    // One-cycle glitch inside a data bit at each of the three sample points.
    for (int o = H - 1; o <= H + 1; o++) begin
      send(0, 9'h0A5, 1'b0, 1'b1, 1'b1, 3, o);
      hold(0, 1'b1, C);
    end

    // Random frames, random gaps (including back-to-back), random glitches.
    for (int inst = 0; inst < 3; inst++) begin
      for (int f = 0; f < 14; f++) begin
        d  = 9'($urandom);
        pb = 1'($urandom);
        s0 = ($urandom_range(0, 7) != 0);
        s1 = ($urandom_range(0, 7) != 0);
        gb = -1;
        go = 0;
        if ($urandom_range(0, 1) == 1) begin
          gb = $urandom_range(1, DB[inst]);
          go = $urandom_range(H - 1, H + 1);
        end
        gap = $urandom_range(0, 2);
        if ((SB[inst] == 1 && !s0) || (SB[inst] == 2 && !s1)) gap = (gap == 0) ? 1 : gap;
        send(inst, d, pb, s0, s1, gb, go);
        hold(inst, 1'b1, gap * C);
      end
      hold(inst, 1'b1, C);
    end

    // Reset in the middle of data bit 4, then a clean 0x3C frame.
    send(0, 9'h05A, 1'b0, 1'b1, 1'b1, -1, 0);
    hold(0, 1'b1, C);
    hold(0, 1'b0, C);
    hold(0, 1'b1, 4 * C);
    hold(0, 1'b1, C / 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_busy", 0, {31'd0, busy[0]}, 32'd0);
    chk("midreset_byte", 0, {23'd0, byt[0]}, 32'd0);
    chk("midreset_flags", 0, {29'd0, perr[0], ferr[0], brk[0]}, 32'd0);
    chk("midreset_dv", 0, {31'd0, dv[0]}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    hold(0, 1'b1, C);
    send(0, 9'h03C, 1'b0, 1'b1, 1'b1, -1, 0);
    hold(0, 1'b1, 2 * C);

    for (int w = 0; w < 20 * C && (q0.size() + q1.size() + q2.size()) != 0; w++) @(posedge clk);
    @(negedge clk);
    chk("pending_frames", 0, q0.size(), 32'd0);
    chk("pending_frames", 1, q1.size(), 32'd0);
    chk("pending_frames", 2, q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
